// File: rtl/mc_mainfsm_pkg.sv
// mc_pkg: shared state, opcode and datapath-select encodings for the multicycle main FSM
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, BNEEX
  } statetype_t;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  function automatic logic is_mem_state(statetype_t s);
    return s inside {FETCH, MEMRD, MEMWR};
  endfunction
endpackage

// File: rtl/mc_mainfsm_if.sv
// mc_mainfsm_if: control bus between main FSM (master) and datapath (slave); branchne exists only with MAINFSM_BNE_EN
interface mc_mainfsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, memwrite, irwrite, pcwrite, branch, iord;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       mem_err, illegal;
`ifdef MAINFSM_BNE_EN
  logic       branchne;
`endif
  modport master (
    input  op, mem_ready,
    output mem_req, memwrite, irwrite, pcwrite, branch, iord,
    output memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, aluop,
    output mem_err, illegal
`ifdef MAINFSM_BNE_EN
    , output branchne
`endif
  );
  modport slave (
    output op, mem_ready,
    input  mem_req, memwrite, irwrite, pcwrite, branch, iord,
    input  memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, aluop,
    input  mem_err, illegal
`ifdef MAINFSM_BNE_EN
    , input branchne
`endif
  );
endinterface

// File: rtl/mc_mainfsm_wdog.sv
// mainfsm_wdog: counts memory wait cycles and flags a timeout when the limit is reached without mem_ready
module mainfsm_wdog #(
  parameter int MAXWAIT = 15,
  parameter int CNTW    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  input  logic clr,
  output logic timeout
);
  logic [CNTW-1:0] cnt_q, cnt_d;
  assign timeout = active && !mem_ready && (cnt_q == CNTW'(MAXWAIT));
  always_comb cnt_d = clr ? '0 : (active && !mem_ready) ? cnt_q + CNTW'(1) : cnt_q;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/mc_mainfsm.sv
// mc_mainfsm: multicycle MIPS main control FSM with memory watchdog; MAINFSM_BNE_EN adds bne (BNEEX, branchne)
module mc_mainfsm
  import mc_pkg::*;
#(
  parameter int MAXWAIT = 15,
  parameter int CNTW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  mc_mainfsm_if.master  bus
);
  statetype_t state_q, state_d;
  logic mem_err_q, mem_err_d, illegal_q, illegal_d;
  logic active, timeout, clr, run;
  assign active = is_mem_state(state_q);
  assign clr    = state_d != state_q;
  assign run    = !reset;
  mainfsm_wdog #(.MAXWAIT(MAXWAIT), .CNTW(CNTW)) u_wdog (
    .clk, .reset, .active, .mem_ready(bus.mem_ready), .clr, .timeout
  );
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MAINFSM_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
    if (timeout) state_d = FETCH;
    mem_err_d = timeout;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= FETCH;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
      illegal_q <= illegal_d;
    end
  // write strobes that complete a memory access also require mem_ready in that same cycle
  assign bus.mem_req  = run && active;
  assign bus.irwrite  = run && state_q == FETCH && bus.mem_ready;
  assign bus.pcwrite  = run && ((state_q == FETCH && bus.mem_ready) || state_q == JEX);
  assign bus.memwrite = run && state_q == MEMWR && bus.mem_ready;
  assign bus.regwrite = run && state_q inside {MEMWB, RTYPEWB, ADDIWB};
  assign bus.branch   = run && state_q == BEQEX;
  assign bus.iord     = state_q inside {MEMRD, MEMWR};
  assign bus.memtoreg = state_q == MEMWB;
  assign bus.regdst   = state_q == RTYPEWB;
  assign bus.alusrca  = state_q inside {MEMADR, RTYPEEX, BEQEX, ADDIEX, BNEEX};
  assign bus.alusrcb  = (state_q == FETCH) ? SRCB_FOUR :
                        (state_q == DECODE) ? SRCB_IMMSH :
                        (state_q inside {MEMADR, ADDIEX}) ? SRCB_IMM : SRCB_B;
  assign bus.pcsrc    = (state_q inside {BEQEX, BNEEX}) ? PCSRC_ALUOUT :
                        (state_q == JEX) ? PCSRC_JUMP : PCSRC_ALU;
  assign bus.aluop    = (state_q == RTYPEEX) ? ALUOP_FUNCT :
                        (state_q inside {BEQEX, BNEEX}) ? ALUOP_SUB : ALUOP_ADD;
  assign bus.mem_err  = mem_err_q;
  assign bus.illegal  = illegal_q;
`ifdef MAINFSM_BNE_EN
  assign bus.branchne = run && state_q == BNEEX;
`endif
endmodule

// File: doc/mc_mainfsm.md
Name: mc_mainfsm

Overview:
- Multicycle main control FSM for the 32-bit MIPS-subset datapath; sits directly upstream of the ALU decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
- Produces aluop[1:0] for the ALU decoder: 00 add, 01 sub, 10 use funct.
- Waits on a memory ready handshake, with a watchdog that aborts a stuck memory access.

Parameters:
- MAXWAIT, 15, maximum consecutive cycles a memory state may wait for mem_ready before abort (1..255).
- CNTW, 8, width of the wait counter; must satisfy 2**CNTW > MAXWAIT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instruction opcode from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access requested (FETCH, MEMRD, MEMWR).
- memwrite  output  1  data memory write strobe.
- irwrite  output  1  instruction register load.
- pcwrite  output  1  unconditional PC load.
- branch  output  1  branch-equal qualifier (PC loads if zero=1).
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  output  1  register writeback source: 0 = ALUOut, 1 = Data.
- regdst  output  1  destination register: 0 = rt, 1 = rd.
- regwrite  output  1  register file write enable.
- alusrca  output  1  SrcA: 0 = PC, 1 = register A.
- alusrcb  output  2  SrcB: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- aluop  output  2  to the ALU decoder.
- mem_err  output  1  one-cycle pulse on watchdog abort.
- illegal  output  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous, active-high.
- On a reset edge: state = FETCH, wait counter = 0, mem_err = 0, illegal = 0.
- While reset = 1, all write enables, branch and mem_req are forced to 0.
- Outputs are Moore-decoded from state, with these exceptions:
  - In FETCH, irwrite and pcwrite are asserted only in the cycle where mem_ready = 1.
  - In MEMWR, memwrite is asserted only in the cycle where mem_ready = 1.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- States and outputs (unlisted outputs are 0):
  - FETCH: mem_req, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. Go to DECODE when mem_ready, else stay.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. lw/sw go to MEMADR; R-type to RTYPEEX; beq to BEQEX; addi to ADDIEX; j to JEX; any other opcode pulses illegal and returns to FETCH.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. lw goes to MEMRD, sw to MEMWR.
  - MEMRD: mem_req, iord=1. Go to MEMWB on mem_ready.
  - MEMWB: regdst=0, memtoreg=1, regwrite. Go to FETCH.
  - MEMWR: mem_req, iord=1. Go to FETCH on mem_ready.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Go to RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite. Go to FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch. Go to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite. Go to FETCH.
  - JEX: pcsrc=10, pcwrite. Go to FETCH.
- Instruction latency with zero wait states: lw 5 cycles; sw and R-type 4; addi 4; beq and j 3.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle a mem_req state sees mem_ready = 0.
  - When counter == MAXWAIT with mem_ready still 0: the next state is FETCH, mem_err pulses in that cycle, and no write enable is asserted.
  - mem_ready = 1 in the same cycle the counter hits MAXWAIT counts as success; no abort.
- op is sampled only in DECODE and MEMADR; changes in other states are ignored.
- Reset mid-instruction abandons the instruction; no partial write enable is asserted after the reset edge.

Optional Feature:
- Macro: MAINFSM_BNE_EN.
- Defined: opcode 000101 (bne) decodes to state BNEEX, which drives the same outputs as BEQEX except branch=0, plus extra output port branchne=1. Go to FETCH.
- Undefined: the branchne port is absent and 000101 is illegal.

Decomposition:
- Package mc_pkg holds:
  - state enum statetype_t;
  - opcode localparams OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE;
  - aluop constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - alusrcb and pcsrc encodings.
- One sub-module: mainfsm_wdog, holding the wait counter and the timeout compare.

Test Plan:
- Reset, then release with op=100011 and mem_ready=1 constantly: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; back in FETCH in cycle 6.
- R-type op=000000: aluop=10 only in RTYPEEX; regdst=1 and regwrite=1 in the following cycle; 4 cycles total.
- beq op=000100: BEQEX shows aluop=01, pcsrc=01, branch=1; j op=000010: JEX shows pcwrite=1, pcsrc=10; both return to FETCH.
- FETCH with mem_ready low for 3 cycles then high: mem_req held for 4 cycles; irwrite=1 only in cycle 4; no mem_err.
- MEMRD with mem_ready held low and MAXWAIT=15: mem_err pulses exactly once; next state FETCH; regwrite never asserted.
- op=111111 in DECODE: illegal pulses for 1 cycle and FETCH follows. With MAINFSM_BNE_EN defined, op=000101 gives branchne=1 and illegal=0.
